// File: rtl/key_debouncer_if.sv
// Key debouncer signal bundle: raw key input and tick enable in, debounced level/pulses/count out.
interface key_debouncer_if;
  logic       key_n;
  logic       tick;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  modport master (
    output key_n, tick,
    input  pressed, press_pulse, release_pulse, press_count
  );

  modport slave (
    input  key_n, tick,
    output pressed, press_pulse, release_pulse, press_count
  );
endinterface

// File: rtl/key_debouncer.sv
// Debounces an active-low key via a 2-flop synchronizer and a tick-driven FSM; registered press/release pulses.
// Optional auto-repeat of press_pulse while held: define KEY_DEBOUNCER_AUTOREPEAT_EN.
module key_debouncer #(
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic            clk,
  input  logic            reset,
  key_debouncer_if.slave  kif
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [7:0] LAST = 8'(STABLE_TICKS - 1);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       sync1, sync2, raw;
  logic       press_q, release_q;
  logic       press_next, release_next;
  logic [7:0] count_q;

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  logic [15:0] rep_cnt, rep_cnt_next;
  logic        repeating, repeating_next;
  logic [15:0] rep_target;

  // First repeat waits the long delay, later ones use the shorter rate.
  assign rep_target = repeating ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

  // Released level is 1, so the synchronizer resets high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= kif.key_n;
      sync2 <= sync1;
    end
  end

  assign raw = ~sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      press_q   <= press_next;
      release_q <= release_next;
      if (press_next) count_q <= count_q + 8'd1;
    end
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt   <= 16'd0;
      repeating <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_next;
      repeating <= repeating_next;
    end
  end
`endif

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    rep_cnt_next   = rep_cnt;
    repeating_next = repeating;
`endif
    case (state)
      IDLE: begin
        if (raw) begin
          state_next = PRESS_WAIT;
          cnt_next   = 8'd0;
        end
      end
      PRESS_WAIT: begin
        if (!raw) begin
          state_next = IDLE;
        end else if (kif.tick) begin
          if (cnt == LAST) begin
            state_next = HELD;
            press_next = 1'b1;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
            rep_cnt_next   = 16'd0;
            repeating_next = 1'b0;
`endif
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
      end
      HELD: begin
        if (!raw) begin
          state_next = RELEASE_WAIT;
          cnt_next   = 8'd0;
        end
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
        else if (kif.tick) begin
          if (rep_cnt == rep_target - 16'd1) begin
            press_next     = 1'b1;
            rep_cnt_next   = 16'd0;
            repeating_next = 1'b1;
          end else begin
            rep_cnt_next = rep_cnt + 16'd1;
          end
        end
`endif
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed returns to HELD silently.
        if (raw) begin
          state_next = HELD;
        end else if (kif.tick) begin
          if (cnt == LAST) begin
            state_next   = IDLE;
            release_next = 1'b1;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign kif.pressed       = (state == HELD) || (state == RELEASE_WAIT);
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = release_q;
  assign kif.press_count   = count_q;

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter STABLE_TICKS, default 4: number of consecutive sampled ticks a new key level must hold before it is accepted; legal range 1..255.
REQ-002 Parameter REPEAT_DELAY, default 32: ticks held before the first auto-repeat pulse (used only with KEY_DEBOUNCER_AUTOREPEAT_EN).
REQ-003 Parameter REPEAT_RATE, default 8: ticks between subsequent auto-repeat pulses (used only with KEY_DEBOUNCER_AUTOREPEAT_EN).
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 key_n  input  1: raw KEY pin, asynchronous to clk, 0 = pressed.
REQ-007 tick  input  1: sample enable from the clock divider; debounce counting advances only on cycles with tick=1.
REQ-008 pressed  output  1: debounced level, 1 = key held.
REQ-009 press_pulse  output  1: one-clk pulse per accepted press (and per repeat when enabled); feeds counter step/enable.
REQ-010 release_pulse  output  1: one-clk pulse per accepted release.
REQ-011 press_count  output  8: number of press_pulse assertions since reset, modulo 256.

Function
REQ-012 key_n shall pass through a two-flop synchronizer; raw = NOT sync2; only raw is used downstream.
REQ-013 FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; 8-bit debounce counter cnt.
REQ-014 IDLE: raw=1 -> PRESS_WAIT, cnt=0; else stay.
REQ-015 PRESS_WAIT: raw=0 on any cycle (tick or not) -> IDLE, no pulse; raw=1 and tick=1 and cnt=STABLE_TICKS-1 -> HELD with press_pulse=1 next cycle; raw=1 and tick=1 otherwise -> cnt+1.
REQ-016 HELD: raw=0 -> RELEASE_WAIT, cnt=0; else stay.
REQ-017 RELEASE_WAIT: raw=1 on any cycle -> HELD with no pulse (bounce); raw=0 and tick=1 and cnt=STABLE_TICKS-1 -> IDLE with release_pulse=1 next cycle; raw=0 and tick=1 otherwise -> cnt+1.
REQ-018 pressed shall be 1 exactly while state is HELD or RELEASE_WAIT.
REQ-019 press_pulse and release_pulse shall be registered, high for exactly one clk, never both high together.
REQ-020 Latency with tick=1: press_pulse high in the cycle after the (STABLE_TICKS+3)th rising edge following key_n low setup; release_pulse symmetric.
REQ-021 press_count shall increment by 1 in the cycle press_pulse is high, wrapping 255 -> 0.
REQ-022 tick=0 shall freeze cnt and the repeat counter; glitches of raw still abort PRESS_WAIT/RELEASE_WAIT.

Reset
REQ-023 reset=1 shall immediately force sync flops to 1 (released), state=IDLE, cnt=0, repeat counter=0, pressed=0, press_pulse=0, release_pulse=0, press_count=0.
REQ-024 Reset asserted mid-press shall produce no pulse; after deassertion a still-held key shall be re-debounced from IDLE and generate one press_pulse.

Configuration
REQ-025 With KEY_DEBOUNCER_AUTOREPEAT_EN defined: in HELD, a 16-bit repeat counter counts ticks; press_pulse asserts after REPEAT_DELAY ticks, then every REPEAT_RATE ticks while held; counter cleared on entry from PRESS_WAIT, paused (not cleared) during RELEASE_WAIT and on bounce back to HELD.
REQ-026 Without KEY_DEBOUNCER_AUTOREPEAT_EN: repeat counter absent; exactly one press_pulse per accepted press; REPEAT_* parameters ignored.

Verification
REQ-027 tick=1, STABLE_TICKS=4, key_n 1->0 held -> press_pulse single pulse 7 edges later, pressed=1, press_count=1.
REQ-028 key_n low for 3 ticks then high (STABLE_TICKS=4) -> no press_pulse, pressed stays 0, press_count=0.
REQ-029 Held key, key_n bounces high for 2 ticks then low -> pressed stays 1, no release_pulse, no extra press_pulse.
REQ-030 tick asserted every 4th cycle, STABLE_TICKS=4 -> press accepted only after 4 ticks (~16 cycles after sync), release_pulse 1 cycle after release debounce.
REQ-031 256 clean presses -> press_count wraps to 0; reset asserted mid-PRESS_WAIT -> all outputs 0 asynchronously, no pulse.
REQ-032 With KEY_DEBOUNCER_AUTOREPEAT_EN, tick=1, hold 32+8+8 ticks after acceptance -> 3 press_pulses total beyond the initial one at delays 32, 40, 48; without macro -> exactly 1.
